// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: issues word fetches to instruction memory,
// tracks one outstanding request, and buffers returned words tagged with their PC.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    input  logic        inst_ready,
    output logic        misalign_err
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic               req_valid_q, req_valid_d;
    logic               misalign_q, misalign_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               head_valid_q, head_valid_d;
    fetch_entry_t       head_q, head_d;
    logic [31:0]        head_pc4_q, head_pc4_d;
    fetch_entry_t       buf_mem [BUF_DEPTH];
    fetch_entry_t       push_entry;
    logic               hs;
    logic               push;
    logic               pop;

    // State, PC, credit and buffer bookkeeping registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= {RESET_PC[31:2], 2'b00};
            req_valid_q  <= 1'b0;
            misalign_q   <= 1'b0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
            head_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_valid_q  <= req_valid_d;
            misalign_q   <= misalign_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
            head_pc4_q   <= head_pc4_d;
        end
    end

    // Buffer storage; contents are only meaningful below count_q
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr_q] <= push_entry;
        end
    end

    // Next-state, fetch PC, credit and buffer head computation
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        misalign_d   = misalign_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        head_valid_d = head_valid_q;
        head_d       = head_q;
        head_pc4_d   = head_pc4_q;

        hs   = (state_q == S_REQ) && req_valid_q && imem_req_ready;
        push = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
        pop  = head_valid_q && inst_ready && !redirect_valid;

        // fetch_pc already advanced past the outstanding word while in WAIT
        push_entry.pc   = fetch_pc_q - 32'd4;
        push_entry.data = imem_rsp_data;

        unique case (state_q)
            S_REQ:   if (hs) state_d = redirect_valid ? S_DROP : S_WAIT;
            S_WAIT:  if (imem_rsp_valid) state_d = S_REQ;
                     else if (redirect_valid) state_d = S_DROP;
            S_DROP:  if (imem_rsp_valid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end

        if (redirect_valid) begin
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            head_valid_d = 1'b0;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            if (count_d == '0) begin
                head_valid_d = 1'b0;
            end else if (pop && (count_q > CNT_W'(1))) begin
                head_valid_d = 1'b1;
                head_d       = buf_mem[rd_ptr_q + PTR_W'(1)];
                head_pc4_d   = head_d.pc + 32'd4;
            end else if (push && ((count_q == '0) || pop)) begin
                head_valid_d = 1'b1;
                head_d       = push_entry;
                head_pc4_d   = push_entry.pc + 32'd4;
            end
        end

        // Outstanding is zero whenever the next state is REQ, so only the buffer counts
        req_valid_d = (state_d == S_REQ) && (count_d < FULL_CNT);
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc_q;
    assign inst_valid     = head_valid_q;
    assign inst_data      = head_q.data;
    assign inst_pc        = head_q.pc;
    assign inst_pc4       = head_pc4_q;
    assign misalign_err   = misalign_q;

    // Credit accounting must never let a push land on a full buffer
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == FULL_CNT)));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a small latency-programmable memory responder.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        inst_ready;
    logic        misalign_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] hs_q[$];
    logic [31:0] pp_q[$];
    logic [31:0] pd_q[$];
    logic [31:0] p4_q[$];

    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          mem_lat;

    pc_fetch_unit #(
        .RESET_PC  (32'h0000_3000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_pc4       (inst_pc4),
        .inst_ready     (inst_ready),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] at_q(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: log handshakes/pops seen this cycle, then update the memory responder
    task automatic tick();
        logic        hs;
        logic [31:0] hs_addr;
        logic        rf;
        hs      = rst_n && imem_req_valid && imem_req_ready;
        hs_addr = imem_req_addr;
        rf      = imem_rsp_valid;
        if (rst_n && !redirect_valid && inst_valid && inst_ready) begin
            pp_q.push_back(inst_pc);
            pd_q.push_back(inst_data);
            p4_q.push_back(inst_pc4);
        end
        if (hs) hs_q.push_back(hs_addr);
        @(posedge clk);
        @(negedge clk);
        if (rf) imem_rsp_valid = 1'b0;
        if (hs) begin
            pend      = 1'b1;
            pend_addr = hs_addr;
            pend_cnt  = mem_lat;
        end
        if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word_of(pend_addr);
                pend           = 1'b0;
            end
        end
    endtask

    task automatic clear_logs();
        hs_q.delete();
        pp_q.delete();
        pd_q.delete();
        p4_q.delete();
    endtask

    task automatic check_zeroed(input string tag);
        check({tag, "_req_valid"},  32'(imem_req_valid), 32'd0);
        check({tag, "_inst_valid"}, 32'(inst_valid),     32'd0);
        check({tag, "_inst_data"},  inst_data,           32'd0);
        check({tag, "_inst_pc"},    inst_pc,             32'd0);
        check({tag, "_inst_pc4"},   inst_pc4,            32'd0);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        pend           = 1'b0;
        mem_lat        = 1;
        tick();
        tick();
        check_zeroed("rst");
        check("rst_misalign", 32'(misalign_err), 32'd0);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic run_until_hs(input int n, input int budget, input string tag);
        int b;
        b = budget;
        while ((hs_q.size() < n) && (b > 0)) begin
            tick();
            b--;
        end
        check({tag, "_hs_timeout"}, 32'(hs_q.size()), 32'(n));
    endtask

    task automatic redirect_tick(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        logic found;
        int   b;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        inst_ready     = 1'b0;
        pend           = 1'b0;
        pend_addr      = 32'd0;
        pend_cnt       = 0;
        mem_lat        = 1;
        @(negedge clk);

        // Streaming fetch with exact latency of the first instruction
        do_reset();
        inst_ready = 1'b1;
        tick();
        check("t1_req_valid0", 32'(imem_req_valid), 32'd1);
        check("t1_req_addr0",  imem_req_addr,       32'h0000_3000);
        tick();
        check("t1_wait_req",   32'(imem_req_valid), 32'd0);
        check("t1_wait_inst",  32'(inst_valid),     32'd0);
        tick();
        check("t1_lat_valid",  32'(inst_valid), 32'd1);
        check("t1_lat_pc",     inst_pc,         32'h0000_3000);
        check("t1_lat_pc4",    inst_pc4,        32'h0000_3004);
        check("t1_lat_data",   inst_data,       word_of(32'h0000_3000));
        repeat (9) tick();
        check("t1_hs0", at_q(hs_q, 0), 32'h0000_3000);
        check("t1_hs1", at_q(hs_q, 1), 32'h0000_3004);
        check("t1_hs2", at_q(hs_q, 2), 32'h0000_3008);
        check("t1_pc0", at_q(pp_q, 0), 32'h0000_3000);
        check("t1_pc1", at_q(pp_q, 1), 32'h0000_3004);
        check("t1_pc2", at_q(pp_q, 2), 32'h0000_3008);
        check("t1_d1",  at_q(pd_q, 1), word_of(32'h0000_3004));
        check("t1_p40", at_q(p4_q, 0), 32'h0000_3004);

        // Backpressure on request channel, then buffer-full credit stall
        do_reset();
        imem_req_ready = 1'b0;
        repeat (4) tick();
        check("t2_hold_valid", 32'(imem_req_valid), 32'd1);
        check("t2_hold_addr",  imem_req_addr,       32'h0000_3000);
        imem_req_ready = 1'b1;
        repeat (10) tick();
        check("t2_nreq",       32'(hs_q.size()),    32'd2);
        check("t2_stall",      32'(imem_req_valid), 32'd0);
        check("t2_head_pc",    inst_pc,             32'h0000_3000);
        inst_ready = 1'b1;
        repeat (10) tick();
        check("t2_resume", at_q(hs_q, 2), 32'h0000_3008);
        check("t2_pc0",    at_q(pp_q, 0), 32'h0000_3000);
        check("t2_pc1",    at_q(pp_q, 1), 32'h0000_3004);
        check("t2_pc2",    at_q(pp_q, 2), 32'h0000_3008);

        // Redirect while waiting on 0x3004
        do_reset();
        mem_lat    = 3;
        inst_ready = 1'b1;
        run_until_hs(2, 30, "t3");
        redirect_tick(32'h0000_4000);
        repeat (12) tick();
        check("t3_hs_next", at_q(hs_q, 2), 32'h0000_4000);
        check("t3_pc0",     at_q(pp_q, 0), 32'h0000_3000);
        check("t3_pc1",     at_q(pp_q, 1), 32'h0000_4000);
        check("t3_d1",      at_q(pd_q, 1), word_of(32'h0000_4000));

        // Redirect coincident with the 0x3008 handshake
        do_reset();
        inst_ready = 1'b1;
        found = 1'b0;
        b = 30;
        while (!found && (b > 0)) begin
            if (imem_req_valid && (imem_req_addr == 32'h0000_3008)) found = 1'b1;
            else begin
                tick();
                b--;
            end
        end
        check("t4_found", 32'(found), 32'd1);
        redirect_tick(32'h0000_5000);
        check("t4_flushed", 32'(inst_valid), 32'd0);
        repeat (10) tick();
        check("t4_hs_3008", at_q(hs_q, 2), 32'h0000_3008);
        check("t4_hs_next", at_q(hs_q, 3), 32'h0000_5000);
        check("t4_pc0",     at_q(pp_q, 0), 32'h0000_3000);
        check("t4_pc1",     at_q(pp_q, 1), 32'h0000_5000);
        check("t4_d1",      at_q(pd_q, 1), word_of(32'h0000_5000));

        // Misaligned redirect sets the sticky flag
        do_reset();
        inst_ready = 1'b1;
        redirect_tick(32'h0000_6002);
        check("t5_addr",     imem_req_addr,       32'h0000_6000);
        check("t5_valid",    32'(imem_req_valid), 32'd1);
        check("t5_misalign", 32'(misalign_err),   32'd1);
        repeat (8) tick();
        check("t5_sticky",   32'(misalign_err),   32'd1);
        check("t5_hs0",      at_q(hs_q, 0),       32'h0000_6000);

        // PC wraparound at the top of the address space
        do_reset();
        check("t6_misalign_clr", 32'(misalign_err), 32'd0);
        inst_ready = 1'b1;
        redirect_tick(32'hFFFF_FFFC);
        repeat (10) tick();
        check("t6_hs0",  at_q(hs_q, 0), 32'hFFFF_FFFC);
        check("t6_hs1",  at_q(hs_q, 1), 32'h0000_0000);
        check("t6_pc0",  at_q(pp_q, 0), 32'hFFFF_FFFC);
        check("t6_p40",  at_q(p4_q, 0), 32'h0000_0000);
        check("t6_pc1",  at_q(pp_q, 1), 32'h0000_0000);
        check("t6_p41",  at_q(p4_q, 1), 32'h0000_0004);
        check("t6_misalign", 32'(misalign_err), 32'd0);

        // Reset while a response is outstanding; the late response must be ignored
        do_reset();
        mem_lat    = 3;
        inst_ready = 1'b1;
        run_until_hs(1, 20, "t7");
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        check_zeroed("t7_rst");
        rst_n = 1'b1;
        repeat (4) tick();
        check("t7_late_drop", 32'(inst_valid),     32'd0);
        check("t7_req_valid", 32'(imem_req_valid), 32'd1);
        check("t7_req_addr",  imem_req_addr,       32'h0000_3000);
        clear_logs();
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        repeat (8) tick();
        check("t7_hs0", at_q(hs_q, 0), 32'h0000_3000);
        check("t7_pc0", at_q(pp_q, 0), 32'h0000_3000);
        check("t7_d0",  at_q(pd_q, 0), word_of(32'h0000_3000));
        check("t7_pc1", at_q(pp_q, 1), 32'h0000_3004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and the instruction-fetch side of the CPU.
- Consumes redirect targets (jumps, taken branches, jr) produced by next-PC logic.
- Issues word fetches to instruction memory over a valid/ready request channel with a separate response channel.
- Buffers returned instructions, tagged with their PC, for the decode stage.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded at reset; bits [1:0] must be 0.
- BUF_DEPTH, 2, instruction buffer entries; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active low.
- redirect_valid  input  1  control-flow redirect this cycle.
- redirect_pc  input  32  redirect target.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  fetch word address.
- imem_req_ready  input  1  memory accepts request.
- imem_rsp_valid  input  1  fetch data returned (exactly one per accepted request, ≥1 cycle after acceptance).
- imem_rsp_data  input  32  instruction word.
- inst_valid  output  1  buffer head valid.
- inst_data  output  32  head instruction.
- inst_pc  output  32  head PC.
- inst_pc4  output  32  head PC + 4.
- inst_ready  input  1  decode consumes head.
- misalign_err  output  1  sticky: a redirect had pc[1:0] != 0.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - fetch_pc = RESET_PC; state = REQ.
  - Buffer emptied; misalign_err = 0.
  - imem_req_valid, inst_valid = 0; inst_data, inst_pc, inst_pc4 = 0.
  - Reset mid-operation abandons any outstanding request. A response arriving after reset is dropped: the state is not WAIT.
- One outstanding request maximum.
- Credit rule: request only while (buffer count + outstanding) < BUF_DEPTH.
- States:
  - REQ: imem_req_valid = credit available; imem_req_addr = fetch_pc. On handshake (valid & ready): fetch_pc += 4 (wraps mod 2^32), go to WAIT.
  - WAIT: imem_req_valid = 0. On imem_rsp_valid: push {pc, data} into the buffer, go to REQ.
  - DROP: imem_req_valid = 0. On imem_rsp_valid: discard the data, go to REQ.
- Redirect (highest priority, same cycle):
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Buffer flushed; any pop and any push that cycle are cancelled.
  - misalign_err set if redirect_pc[1:0] != 0.
  - Next state depends on the current state:
    - REQ with a handshake in the same cycle → DROP.
    - REQ without a handshake → REQ.
    - WAIT with imem_rsp_valid in the same cycle → REQ (the response is discarded).
    - WAIT without imem_rsp_valid → DROP.
    - DROP with imem_rsp_valid in the same cycle → REQ.
    - DROP without imem_rsp_valid → DROP.
- Buffer:
  - FIFO, registered head outputs. inst_valid = not empty.
  - Pop on inst_valid & inst_ready.
  - Simultaneous push and pop allowed when full or empty. When empty, the pushed entry appears the next cycle; no same-cycle bypass.
  - Overflow is impossible by the credit rule. An assertion flags any push while full.
- inst_pc4 = inst_pc + 4, modulo 2^32.
- Latency: request accepted at cycle N, response at N+k → inst_valid at N+k+1.
- imem_req_addr is held stable while imem_req_valid=1 and ready=0. A redirect may change it; this is the only exception.

Test Plan:
- Release reset, memory ready=1, 1-cycle response, inst_ready=1 → addresses 0x3000, 0x3004, 0x3008…; inst_pc matches each; inst_pc4 = 0x3004 for the first instruction.
- inst_ready=0 held → exactly BUF_DEPTH (2) requests issued, then imem_req_valid=0. Raise inst_ready → fetching resumes at 0x3008.
- Redirect to 0x0000_4000 while in WAIT for 0x3004 → the 0x3004 response is dropped, buffer flushed, next request 0x4000. First inst_pc after the redirect is 0x4000.
- Redirect to 0x5000 in the same cycle as the 0x3008 request handshake → enter DROP, the 0x3008 data is never presented, next request 0x5000.
- Redirect to 0x0000_6002 → request addr 0x6000, misalign_err=1 and it stays 1 until reset.
- fetch_pc = 0xFFFF_FFFC with a handshake → next addr 0x0000_0000; inst_pc4 for that entry = 0x0000_0000. Assert rst_n=0 while in WAIT → outputs zeroed, next request 0x3000, the late response is ignored.
